car_detector: RTL and testbench
===============================

# car_detector

Front-end conditioner for the country-road vehicle loop; produces the `sensor` request consumed by the highway controller FSM. Synchronises and debounces the raw loop input and counts arriving cars in a saturating queue counter. While the controller grants the country road via `enable_countryroad`, it drains one car per `pulse`. `sensor` stays asserted while any car is queued.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before the filtered level changes; must be ≥2.
- `MAX_QUEUE`, 15: saturation value of the car counter.
- `CNT_W`, 4: counter width; must satisfy `MAX_QUEUE < 2**CNT_W`.
- `STUCK_SEC`, 30: stuck-loop threshold in seconds (used only with `LOOP_FAULT_EN`).
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `loop_raw` in 1: asynchronous raw loop-detector level; 1 means vehicle present.
- `pulse` in 1: one-cycle 1 s tick from `pulse_1s`.
- `enable_countryroad` in 1: high while the country road holds green.
- `sensor` out 1: registered; equals `car_count != 0`, masked by fault.
- `car_count` out CNT_W: registered queue depth.
- `overflow` out 1: sticky; an arrival occurred at `MAX_QUEUE`.
- `loop_fault` out 1: sticky stuck-loop flag; constant 0 without `LOOP_FAULT_EN`.

## Operation
- **Synchroniser.** Two flops, `loop_raw` → `s1` → `s2`. Both reset to 0.
- **Debounce FSM.** States `ABSENT`, `ARRIVING`, `PRESENT`, `LEAVING`. Reset state is `ABSENT`.
  - `ABSENT`: on `s2=1`, go to `ARRIVING` with `db_cnt=1`.
  - `ARRIVING`: on `s2=0`, return to `ABSENT` and clear `db_cnt`. Otherwise increment `db_cnt`. When `db_cnt` reaches `DEBOUNCE_CYCLES-1` with `s2=1`, go to `PRESENT` and issue a one-cycle `arrive` strobe.
  - `PRESENT` and `LEAVING` mirror `ABSENT` and `ARRIVING` with the level inverted. There is no strobe on leaving.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the filtered level.
- **Drain.** `depart = pulse & enable_countryroad & (car_count != 0)`.
- **Counter update**, evaluated in priority order:
  - `arrive & depart`: count unchanged.
  - `arrive` alone: increment. If already at `MAX_QUEUE`, hold and set `overflow`.
  - `depart` alone: decrement. The count never goes below 0.
- **`sensor` output.** Registered from the next-state count, so it changes in the same cycle as `car_count`.
- **Clearing.** `overflow` and `loop_fault` clear only on `rst`.
- **Reset values.** All outputs 0, FSM in `ABSENT`, `db_cnt=0`. Reset mid-debounce discards partial progress. A vehicle still on the loop after reset is re-counted after the full latency.

## Timing
- `s2` follows `loop_raw` by 2 cycles.
- `arrive` pulses `DEBOUNCE_CYCLES` cycles after `s2` first goes high, i.e. `DEBOUNCE_CYCLES+2` cycles after `loop_raw` rises.
- `car_count` and `sensor` update on the cycle after `arrive`: latency `DEBOUNCE_CYCLES+3` from raw rise.
- Drain: `car_count` and `sensor` update on the edge after the cycle in which `depart` is high.
- `sensor` falls on the same edge as `car_count` reaches 0.
- `pulse` with `enable_countryroad=0` has no effect on the counter.

## Configuration
- **`LOOP_FAULT_EN` defined:**
  - A seconds counter increments on `pulse` while the FSM is in `PRESENT` and `enable_countryroad=1`. It clears on any other state or when `enable_countryroad=0`.
  - When it reaches `STUCK_SEC`: set `loop_fault`, clear `car_count`, and hold `sensor` at 0 until the FSM next enters `ABSENT`.
  - After that, arrivals count normally; `loop_fault` stays set.
- **`LOOP_FAULT_EN` undefined:** no seconds counter, `loop_fault` tied to 0, `sensor` never masked.

## Structure
- Shared package `traffic_pkg` holds:
  - The debounce state enum `det_state_t` (`ABSENT`/`ARRIVING`/`PRESENT`/`LEAVING`).
  - Default constants `DEBOUNCE_CYCLES_DEF` and `MAX_QUEUE_DEF`.
- One sub-module, `loop_debounce`: synchroniser plus debounce FSM, outputting the filtered level and the `arrive` strobe.
- Counter, drain and fault logic stay in `car_detector`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `MAX_QUEUE=3`, `STUCK_SEC=2`.
- **Glitch rejection.** `loop_raw` high for 3 cycles then low → `car_count` stays 0, `sensor` stays 0.
- **Single arrival.** `loop_raw` rises and holds → `car_count=1` and `sensor=1` exactly 7 cycles after the rise; release the loop, count stays 1.
- **Saturation.** 5 clean arrivals with `enable_countryroad=0` → `car_count=3`; `overflow=1` from the 4th arrival onward.
- **Drain.**
  - `car_count=2`, `enable_countryroad=1`, two `pulse`s → count 1 then 0.
  - `sensor` drops on the edge after the second pulse.
  - A third pulse leaves the count at 0.
- **Simultaneous events.** `arrive` coincident with `depart` at count 1 → count stays 1, `sensor` stays 1.
- **Reset and stuck loop.**
  - `rst` mid-`ARRIVING` → all outputs 0; the held loop re-counts after 7 cycles.
  - With `LOOP_FAULT_EN`: loop held and `enable_countryroad=1` for 2 pulses → `loop_fault=1`, `car_count=0`, `sensor=0`.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the highway/country-road traffic controller.
// Holds the loop-debounce state encoding and the helpers that decode it.
package traffic_pkg;

  typedef enum logic [1:0] {
    ABSENT   = 2'd0,
    ARRIVING = 2'd1,
    PRESENT  = 2'd2,
    LEAVING  = 2'd3
  } det_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int MAX_QUEUE_DEF       = 15;
  localparam int SYNC_STAGES         = 2;

  // Filtered level: a vehicle is considered present until LEAVING completes.
  function automatic logic det_level_of(input det_state_t s);
    return (s == PRESENT) || (s == LEAVING);
  endfunction

  function automatic logic det_stable_of(input det_state_t s);
    return (s == ABSENT) || (s == PRESENT);
  endfunction

endpackage

// File: rtl/loop_debounce.sv
// Two-flop synchroniser and four-state debounce filter for the raw loop input.
// Emits the filtered level, a settled flag and a one-cycle arrival strobe.
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic level,
  output logic stable,
  output logic arrive
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s2;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= loop_raw;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s2 = sync_reg[SYNC_STAGES-1];

  det_state_t    state_reg, state_next;
  logic [CW-1:0] db_cnt_reg, db_cnt_next;
  logic          arrive_reg, arrive_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ABSENT;
      db_cnt_reg <= '0;
      arrive_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      db_cnt_reg <= db_cnt_next;
      arrive_reg <= arrive_next;
    end
  end

  // A level change must survive DEBOUNCE_CYCLES consecutive samples; any
  // sample of the old level during the window abandons the transition.
  always_comb begin
    state_next  = state_reg;
    db_cnt_next = db_cnt_reg;
    arrive_next = 1'b0;
    case (state_reg)
      ABSENT: begin
        if (s2) begin
          state_next  = ARRIVING;
          db_cnt_next = CW'(1);
        end
      end
      ARRIVING: begin
        if (!s2) begin
          state_next  = ABSENT;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next  = PRESENT;
          db_cnt_next = '0;
          arrive_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + CW'(1);
        end
      end
      PRESENT: begin
        if (!s2) begin
          state_next  = LEAVING;
          db_cnt_next = CW'(1);
        end
      end
      LEAVING: begin
        if (s2) begin
          state_next  = PRESENT;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next  = ABSENT;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next  = ABSENT;
        db_cnt_next = '0;
      end
    endcase
  end

  assign level  = det_level_of(state_reg);
  assign stable = det_stable_of(state_reg);
  assign arrive = arrive_reg;

endmodule

// File: rtl/car_detector.sv
// Country-road vehicle detector: debounced arrivals feed a saturating queue
// counter drained one car per second of green. Optional macro LOOP_FAULT_EN.
module car_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int MAX_QUEUE       = MAX_QUEUE_DEF,
  parameter int CNT_W           = 4,
  parameter int STUCK_SEC       = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic             pulse,
  input  logic             enable_countryroad,
  output logic             sensor,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow,
  output logic             loop_fault
);

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_QUEUE);

  logic det_level;
  logic det_stable;
  logic arrive;

  loop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .loop_raw(loop_raw),
    .level   (det_level),
    .stable  (det_stable),
    .arrive  (arrive)
  );

  logic             depart;
  logic [CNT_W-1:0] count_reg, count_base, count_next;
  logic             overflow_reg, overflow_next;
  logic             sensor_reg, sensor_next;

  // Simultaneous arrival and departure cancel; arrivals at the limit are lost.
  always_comb begin
    depart        = pulse & enable_countryroad & (count_reg != '0);
    count_base    = count_reg;
    overflow_next = overflow_reg;
    if (arrive && depart) begin
      count_base = count_reg;
    end else if (arrive) begin
      if (count_reg == MAX_COUNT) overflow_next = 1'b1;
      else                        count_base    = count_reg + CNT_W'(1);
    end else if (depart) begin
      count_base = count_reg - CNT_W'(1);
    end
  end

`ifdef LOOP_FAULT_EN
  localparam int SEC_W = $clog2(STUCK_SEC + 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(STUCK_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(STUCK_SEC);

  logic             det_present;
  logic             det_absent;
  logic             stuck;
  logic [SEC_W-1:0] sec_reg, sec_next;
  logic             fault_reg, fault_next;
  logic             mask_reg, mask_next;

  assign det_present = det_level & det_stable;
  assign det_absent  = ~det_level & det_stable;

  // A loop that stays occupied through STUCK_SEC seconds of green is treated
  // as broken: flush the queue and hide the request until the loop clears.
  always_comb begin
    sec_next   = sec_reg;
    fault_next = fault_reg;
    mask_next  = mask_reg;
    stuck      = 1'b0;
    count_next = count_base;
    if (det_present && enable_countryroad) begin
      if (pulse && (sec_reg != SEC_MAX)) sec_next = sec_reg + SEC_W'(1);
      stuck = pulse && (sec_reg == SEC_LAST);
    end else begin
      sec_next = '0;
    end
    if (stuck) begin
      fault_next = 1'b1;
      mask_next  = 1'b1;
      count_next = '0;
    end else if (det_absent) begin
      mask_next = 1'b0;
    end
    sensor_next = (count_next != '0) & ~mask_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_reg   <= '0;
      fault_reg <= 1'b0;
      mask_reg  <= 1'b0;
    end else begin
      sec_reg   <= sec_next;
      fault_reg <= fault_next;
      mask_reg  <= mask_next;
    end
  end

  assign loop_fault = fault_reg;
`else
  logic unused_fault_inputs;

  assign count_next          = count_base;
  assign sensor_next         = (count_next != '0);
  assign loop_fault          = 1'b0;
  assign unused_fault_inputs = ^{det_level, det_stable, (STUCK_SEC > 0)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      sensor_reg   <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      sensor_reg   <= sensor_next;
    end
  end

  assign car_count = count_reg;
  assign overflow  = overflow_reg;
  assign sensor    = sensor_reg;

endmodule

// File: tb/tb_car_detector.sv
// Scoreboard bench for car_detector: expectations are queued with a target
// cycle when stimulus is applied and compared on the falling clock edge.
module tb_car_detector;

  localparam int D    = 4;
  localparam int MAXQ = 3;
  localparam int CW   = 4;
  localparam int STK  = 2;
`ifdef LOOP_FAULT_EN
  localparam logic FAULT_BUILD = 1'b1;
`else
  localparam logic FAULT_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          loop_raw = 1'b0;
  logic          pulse = 1'b0;
  logic          en = 1'b0;
  logic          sensor;
  logic [CW-1:0] car_count;
  logic          overflow;
  logic          loop_fault;

  car_detector #(
    .DEBOUNCE_CYCLES(D),
    .MAX_QUEUE      (MAXQ),
    .CNT_W          (CW),
    .STUCK_SEC      (STK)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .loop_raw          (loop_raw),
    .pulse             (pulse),
    .enable_countryroad(en),
    .sensor            (sensor),
    .car_count         (car_count),
    .overflow          (overflow),
    .loop_fault        (loop_fault)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   at;
    logic [CW-1:0] cnt;
    logic          sen;
    logic          ovf;
    logic          flt;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned ofs, input logic [CW-1:0] cnt, input logic sen,
                           input logic ovf, input logic flt, input string tag);
    exp_t e;
    e.at  = cyc + ofs;
    e.cnt = cnt;
    e.sen = sen;
    e.ovf = ovf;
    e.flt = flt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        check({e.tag, "_missed"}, cyc, e.at);
      end else begin
        check({e.tag, "_count"},    car_count,  e.cnt);
        check({e.tag, "_sensor"},   sensor,     e.sen);
        check({e.tag, "_overflow"}, overflow,   e.ovf);
        check({e.tag, "_fault"},    loop_fault, e.flt);
        $display("cyc=%0d %s count=%0d sensor=%b overflow=%b fault=%b",
                 cyc, e.tag, car_count, sensor, overflow, loop_fault);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [CW-1:0] c_pre, c_post;

    rst = 1'b1;
    edges(3);
    rst = 1'b0;
    expect_at(0, 0, 0, 0, 0, "reset");
    edges(2);

    // Three-cycle glitch must never be counted.
    loop_raw = 1'b1;
    expect_at(8, 0, 0, 0, 0, "glitch_a");
    expect_at(12, 0, 0, 0, 0, "glitch_b");
    edges(3);
    loop_raw = 1'b0;
    edges(14);

    // Single arrival: count appears exactly seven cycles after the rise.
    loop_raw = 1'b1;
    expect_at(6, 0, 0, 0, 0, "arr_early");
    expect_at(7, 1, 1, 0, 0, "arr_exact");
    edges(8);
    loop_raw = 1'b0;
    edges(12);
    expect_at(0, 1, 1, 0, 0, "arr_hold");
    edges(2);

    // Saturation from an empty queue.
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    expect_at(0, 0, 0, 0, 0, "rst_clear");
    edges(2);
    for (k = 1; k <= 5; k++) begin
      c_pre  = CW'((k - 1 > MAXQ) ? MAXQ : k - 1);
      c_post = CW'((k > MAXQ) ? MAXQ : k);
      loop_raw = 1'b1;
      expect_at(6, c_pre, k > 1, k >= 5, 0, $sformatf("sat%0d_pre", k));
      expect_at(7, c_post, 1, k >= 4, 0, $sformatf("sat%0d", k));
      edges(6);
      loop_raw = 1'b0;
      edges(10);
    end

    // Pulse without green is ignored.
    pulse = 1'b1;
    expect_at(1, 3, 1, 1, 0, "pulse_gated");
    edges(1);
    pulse = 1'b0;
    edges(2);

    // Drain one car per pulse, floor at zero.
    en = 1'b1;
    pulse = 1'b1;
    expect_at(1, 2, 1, 1, 0, "drain_2");
    edges(1);
    pulse = 1'b0;
    edges(2);
    pulse = 1'b1;
    expect_at(0, 2, 1, 1, 0, "drain_pre1");
    expect_at(1, 1, 1, 1, 0, "drain_1");
    edges(1);
    pulse = 1'b0;
    edges(2);
    pulse = 1'b1;
    expect_at(0, 1, 1, 1, 0, "drain_pre0");
    expect_at(1, 0, 0, 1, 0, "drain_0");
    edges(1);
    pulse = 1'b0;
    edges(2);
    pulse = 1'b1;
    expect_at(1, 0, 0, 1, 0, "drain_floor");
    edges(1);
    pulse = 1'b0;
    edges(2);

    // Arrival coinciding with a departure at count 1.
    loop_raw = 1'b1;
    expect_at(7, 1, 1, 1, 0, "sim_first");
    edges(6);
    loop_raw = 1'b0;
    edges(10);
    loop_raw = 1'b1;
    expect_at(7, 1, 1, 1, 0, "sim_both");
    edges(6);
    pulse = 1'b1;
    loop_raw = 1'b0;
    edges(1);
    pulse = 1'b0;
    edges(10);
    pulse = 1'b1;
    expect_at(1, 0, 0, 1, 0, "sim_drain");
    edges(1);
    pulse = 1'b0;
    edges(2);

    // Reset in the middle of ARRIVING, loop kept occupied.
    en = 1'b0;
    loop_raw = 1'b1;
    expect_at(7, 1, 1, 1, 0, "pre_rst");
    edges(6);
    loop_raw = 1'b0;
    edges(10);
    loop_raw = 1'b1;
    edges(4);
    rst = 1'b1;
    expect_at(1, 0, 0, 0, 0, "rst_mid");
    edges(1);
    rst = 1'b0;
    expect_at(6, 0, 0, 0, 0, "recount_early");
    expect_at(7, 1, 1, 0, 0, "recount");
    edges(8);

    // Loop stays occupied through two seconds of green.
    en = 1'b1;
    pulse = 1'b1;
    expect_at(1, 0, 0, 0, 0, "stuck_p1");
    edges(1);
    pulse = 1'b0;
    edges(2);
    pulse = 1'b1;
    expect_at(1, 0, 0, 0, FAULT_BUILD, "stuck_p2");
    edges(1);
    pulse = 1'b0;
    edges(2);
    loop_raw = 1'b0;
    edges(12);
    loop_raw = 1'b1;
    expect_at(7, 1, 1, 0, FAULT_BUILD, "post_fault");
    edges(6);
    loop_raw = 1'b0;
    edges(10);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
